// File: rtl/furv_bus_arb.sv
// furv_bus_arb: round-robin arbiter that merges the fetch and data ports of the core
// onto a single request/ack bus. A slave that never answers is cut off by a timeout.
module furv_bus_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [29:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    input  logic        d_mem,
    input  logic        d_write,
    input  logic [29:0] d_addr,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        err,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] count;
    logic       grant_data;
    logic       last_data;
    logic       pick_data;
    logic       any_req;

    // On a tie the master that was not served last gets the bus.
    always_comb begin
        any_req   = i_req | d_mem;
        pick_data = d_mem;
        if (i_req && d_mem) begin
            pick_data = ~last_data;
        end
    end

    assign bus_stb = bus_cyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 8'd0;
            grant_data <= 1'b0;
            last_data  <= 1'b0;
            bus_cyc    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 30'd0;
            bus_sel    <= 4'd0;
            bus_wdata  <= 32'd0;
            i_data     <= 32'd0;
            d_rdata    <= 32'd0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    if (any_req) begin
                        grant_data <= pick_data;
                        bus_cyc    <= 1'b1;
                        count      <= 8'd0;
                        state      <= BUS;
                        if (pick_data) begin
                            bus_we    <= d_write;
                            bus_addr  <= d_addr;
                            bus_sel   <= d_sel;
                            bus_wdata <= d_wdata;
                        end else begin
                            // Fetches are always full-word reads; write data is left as is.
                            bus_we   <= 1'b0;
                            bus_addr <= i_addr;
                            bus_sel  <= 4'b1111;
                        end
                    end
                end

                BUS: begin
                    if (bus_ack) begin
                        bus_cyc <= 1'b0;
                        err     <= 1'b0;
                        state   <= RESP;
                        if (grant_data) begin
                            d_rdata <= bus_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_data <= bus_rdata;
                            i_ack  <= 1'b1;
                        end
                    end else if (count == LAST_COUNT) begin
                        bus_cyc <= 1'b0;
                        err     <= 1'b1;
                        state   <= RESP;
                        if (grant_data) begin
                            d_rdata <= 32'hFFFF_FFFF;
                            d_ack   <= 1'b1;
                        end else begin
                            i_data <= 32'hFFFF_FFFF;
                            i_ack  <= 1'b1;
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end

                RESP: begin
                    i_ack     <= 1'b0;
                    d_ack     <= 1'b0;
                    err       <= 1'b0;
                    last_data <= grant_data;
                    state     <= IDLE;
                end

                default: begin
                    bus_cyc <= 1'b0;
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    err     <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/furv_bus_arb.md
FURV_BUS_ARB -- requirements
Module: furv_bus_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, bus cycles waited for bus_ack before a transfer is aborted (range 2..255).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_req  input  1  instruction-fetch request, read-only, held until i_ack.
REQ-005 i_addr  input  30  instruction word address (pc[31:2]).
REQ-006 i_data  output  32  fetched instruction word.
REQ-007 i_ack  output  1  one-cycle completion pulse to fetch master.
REQ-008 d_mem  input  1  data request (core mem), held until d_ack.
REQ-009 d_write  input  1  data write enable (core mem_write).
REQ-010 d_addr  input  30  data word address.
REQ-011 d_sel  input  4  data byte lane select.
REQ-012 d_wdata  input  32  data write value (core data_out).
REQ-013 d_rdata  output  32  data read value (to core data_in).
REQ-014 d_ack  output  1  one-cycle completion pulse to data master.
REQ-015 err  output  1  one-cycle pulse coincident with i_ack/d_ack when the transfer timed out.
REQ-016 bus_cyc, bus_stb  output  1 each  bus cycle/strobe; always driven equal.
REQ-017 bus_we  output  1  bus write enable.
REQ-018 bus_addr  output  30  bus word address.
REQ-019 bus_sel  output  4  bus byte lanes.
REQ-020 bus_wdata  output  32  bus write data.
REQ-021 bus_rdata  input  32  bus read data, valid when bus_ack=1.
REQ-022 bus_ack  input  1  slave completion.

Function
REQ-023 FSM states IDLE, BUS, RESP; all bus_* and master-side outputs registered.
REQ-024 IDLE: no request -> stay; else grant one master, latch its addr/sel/we/wdata into bus_* regs, assert bus_cyc/bus_stb, go BUS.
REQ-025 Fetch grant forces bus_we=0, bus_sel=4'b1111, bus_wdata unchanged.
REQ-026 Arbitration, both requesting in IDLE: round-robin, master not granted last wins; only one requesting: that one wins.
REQ-027 BUS: bus_* outputs held constant; cycle counter starts 0 on entry, +1 per BUS cycle.
REQ-028 BUS, bus_ack=1: deassert bus_cyc/bus_stb, capture bus_rdata into granted master's data reg (writes: capture too), go RESP, err=0.
REQ-029 BUS, bus_ack=0 and counter = TIMEOUT-1: deassert bus_cyc/bus_stb, load granted master's data reg with 32'hFFFFFFFF, go RESP with err=1.
REQ-030 bus_ack and timeout in same cycle: ack wins, err=0.
REQ-031 RESP: exactly one cycle; granted master's ack=1 (plus err if flagged), non-granted ack=0; next state IDLE; update last-grant.
REQ-032 Masters drop request in the cycle after their ack; IDLE never sees the served request still pending.
REQ-033 Latency: request sampled at edge N -> bus_cyc high cycle N+1; bus_ack sampled at edge M -> master ack high cycle M+1; minimum request-to-ack 3 cycles.
REQ-034 i_data/d_rdata hold last value until next completion to that master; never altered by the other master's transfer.
REQ-035 Request arriving/changing during BUS or RESP ignored until IDLE; request changing while granted is a master protocol violation, not checked.
REQ-036 Bus_ack outside BUS ignored.

Reset
REQ-037 rst=1 at an edge: state IDLE, bus_cyc=bus_stb=bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, i_ack=d_ack=err=0, i_data=d_rdata=0, counter=0, last-grant=fetch (data wins first tie).
REQ-038 Reset mid-transfer (BUS or RESP): aborts silently, no ack or err issued, bus_cyc low from the following cycle.

Verification
REQ-039 Fetch i_addr=30'h40, slave acks 1st BUS cycle with 32'h00500093 -> bus_cyc high 1 cycle, bus_sel=4'hF, bus_we=0, i_ack + i_data=32'h00500093 3 cycles after request, d_ack=0.
REQ-040 Data write d_addr=30'h100, d_sel=4'b0100, d_wdata=32'h00AB0000, ack after 3 wait cycles -> bus_we=1, bus_sel=4'b0100, bus fields stable 4 cycles, d_ack one pulse, err=0.
REQ-041 i_req and d_mem asserted together from reset -> data served first, then fetch; repeat both -> order alternates D,I,D,I.
REQ-042 TIMEOUT=4, data read, slave never acks -> bus_cyc high exactly 4 cycles, d_ack=err=1 same cycle, d_rdata=32'hFFFFFFFF, next fetch completes normally.
REQ-043 bus_ack first asserted in the TIMEOUT-1 counter cycle with 32'h12345678 -> err=0, data=32'h12345678.
REQ-044 rst pulsed during BUS of a fetch -> no i_ack, all outputs at reset values next cycle, subsequent request served normally.
